// File: rtl/rc4_pkg.sv
// Shared types for the RC4 S-array controllers: state encodings, default geometry
// and the verifier check-mode enum.
package rc4_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;

  // bit4 drives v_done and bit3 drives r_rden directly from the state register.
  typedef enum logic [4:0] {
    IDLE        = 5'b00_000,
    SET_ADDR    = 5'b01_001,
    WAIT_DATA   = 5'b00_010,
    COMPARE     = 5'b00_011,
    INC_COUNT   = 5'b00_100,
    VERIFY_DONE = 5'b10_101
  } vm_state_t;

  typedef enum logic {
    MODE_IDENTITY    = 1'b0,
    MODE_PERMUTATION = 1'b1
  } vm_mode_t;

endpackage

// File: rtl/verify_mem_if.sv
// Control and S-RAM read-port signals of the memory verifier.
interface verify_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  // start/v_done form a four-phase level handshake: start rises, v_done rises and
  // holds, start falls, v_done falls. r_rden is a one-cycle read strobe with no
  // back-pressure; r_q must be valid RD_LAT clocks later and stay valid until the
  // next strobe. v_pass, v_err_addr and v_err_count are meaningful while v_done=1.
  logic              start;
  logic [ADDR_W-1:0] r_address;
  logic              r_rden;
  logic [DATA_W-1:0] r_q;
  logic              v_done;
  logic              v_pass;
  logic [ADDR_W-1:0] v_err_addr;
  logic [ADDR_W:0]   v_err_count;

  modport master (
    input  start, r_q,
    output r_address, r_rden, v_done, v_pass, v_err_addr, v_err_count
  );

  modport slave (
    output start, r_q,
    input  r_address, r_rden, v_done, v_pass, v_err_addr, v_err_count
  );
endinterface

// File: rtl/verify_mem_seen_bitmap.sv
// DEPTH x 1 "value already seen" flag array: async clear on reset, sync clear,
// one set port and one combinational test port.
module seen_bitmap #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [IDX_W-1:0] test_idx,
  output logic             test_hit
);
  // When DEPTH covers the whole index space no out-of-range value can occur.
  localparam bit FULL = (DEPTH >= (1 << IDX_W));

  logic [DEPTH-1:0] flags;
  logic             set_ok;
  logic             test_ok;

  assign set_ok  = FULL || (int'(set_idx) < DEPTH);
  assign test_ok = FULL || (int'(test_idx) < DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (clr) begin
      flags <= '0;
    end else if (set_en && set_ok) begin
      flags[set_idx] <= 1'b1;
    end
  end

  assign test_hit = test_ok ? flags[test_idx] : 1'b0;
endmodule

// File: rtl/verify_mem.sv
// Walks S-RAM addresses 0..DEPTH-1 after the init pass and checks the contents:
// identity fill (MODE 0) or permutation / no repeated value (MODE 1).
module verify_mem
  import rc4_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_LAT = 1,
  parameter int MODE   = 0
) (
  input  logic      clk,
  input  logic      reset,
  verify_mem_if.master bus,
  output vm_state_t dbg_state
);
  // One spare count bit so DEPTH = 2^ADDR_W reaches its terminal compare without wrapping.
  localparam int                CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  ERR_MAX  = CNT_W'(DEPTH);
  localparam logic [1:0]        LAT_LOAD = 2'(RD_LAT - 1);

  vm_state_t         state;
  vm_state_t         state_nxt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  err_count;
  logic [ADDR_W-1:0] err_addr;
  logic              pass;
  logic [1:0]        lat_cnt;
  logic              mismatch;
  logic              walk_start;

  assign walk_start = (state == IDLE) && bus.start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (bus.start) state_nxt = SET_ADDR;
      SET_ADDR:    state_nxt = WAIT_DATA;
      WAIT_DATA:   if (lat_cnt == 2'd0) state_nxt = COMPARE;
      COMPARE:     state_nxt = INC_COUNT;
      INC_COUNT:   state_nxt = (count == LAST) ? VERIFY_DONE : SET_ADDR;
      VERIFY_DONE: if (!bus.start) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // r_q only reaches state through COMPARE, so unknown read data elsewhere is harmless.
  generate
    if (MODE == int'(MODE_PERMUTATION)) begin : g_perm
      logic seen_hit;

      seen_bitmap #(
        .DEPTH (DEPTH),
        .IDX_W (DATA_W)
      ) u_seen (
        .clk      (clk),
        .rst_n    (reset),
        .clr      (walk_start),
        .set_en   (state == COMPARE),
        .set_idx  (bus.r_q),
        .test_idx (bus.r_q),
        .test_hit (seen_hit)
      );

      assign mismatch = seen_hit;
    end else begin : g_ident
      assign mismatch = (32'(bus.r_q) != 32'(count));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      err_count <= '0;
      err_addr  <= '0;
      pass      <= 1'b0;
      lat_cnt   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            count     <= '0;
            err_count <= '0;
            err_addr  <= '0;
            pass      <= 1'b1;
          end
        end
        SET_ADDR:  lat_cnt <= LAT_LOAD;
        WAIT_DATA: if (lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
        COMPARE: begin
          if (mismatch) begin
            if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
            if (pass) begin
              err_addr <= count[ADDR_W-1:0];
              pass     <= 1'b0;
            end
          end
        end
        INC_COUNT: if (count != LAST) count <= count + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.r_address   = count[ADDR_W-1:0];
  assign bus.r_rden      = state[3];
  assign bus.v_done      = state[4];
  assign bus.v_pass      = pass;
  assign bus.v_err_addr  = err_addr;
  assign bus.v_err_count = err_count;
  assign dbg_state       = state;
endmodule

// File: tb/tb_verify_mem.sv
// Bench for verify_mem: three instances (identity/RD_LAT=1, permutation/RD_LAT=1,
// identity/RD_LAT=3) read one shared S-RAM image through latency-accurate read models.
`timescale 1ns/1ps
module tb_verify_mem;
  import rc4_pkg::*;

  localparam int AW     = 8;
  localparam int DW     = 8;
  localparam int DEPTH  = 256;
  localparam int N      = 3;
  localparam int MAXCYC = 5000;
  localparam int LAT [N] = '{1, 1, 3};

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  verify_mem_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
  verify_mem_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();
  verify_mem_if #(.ADDR_W(AW), .DATA_W(DW)) if2 ();

  vm_state_t      st_a [N];
  logic [N-1:0]   start_v;
  logic [N-1:0]   rden_v, done_v, pass_v;
  logic [AW-1:0]  addr_a [N];
  logic [AW-1:0]  eaddr_a [N];
  logic [AW:0]    ecnt_a [N];
  logic [DW-1:0]  q_a [N];

  verify_mem #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(1), .MODE(0)) u_id1 (
    .clk(clk), .reset(reset), .bus(if0.master), .dbg_state(st_a[0]));
  verify_mem #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(1), .MODE(1)) u_perm (
    .clk(clk), .reset(reset), .bus(if1.master), .dbg_state(st_a[1]));
  verify_mem #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(3), .MODE(0)) u_id3 (
    .clk(clk), .reset(reset), .bus(if2.master), .dbg_state(st_a[2]));

  assign if0.start = start_v[0];  assign if0.r_q = q_a[0];
  assign if1.start = start_v[1];  assign if1.r_q = q_a[1];
  assign if2.start = start_v[2];  assign if2.r_q = q_a[2];
  assign rden_v  = {if2.r_rden, if1.r_rden, if0.r_rden};
  assign done_v  = {if2.v_done, if1.v_done, if0.v_done};
  assign pass_v  = {if2.v_pass, if1.v_pass, if0.v_pass};
  assign addr_a[0]  = if0.r_address;    assign addr_a[1]  = if1.r_address;    assign addr_a[2]  = if2.r_address;
  assign eaddr_a[0] = if0.v_err_addr;   assign eaddr_a[1] = if1.v_err_addr;   assign eaddr_a[2] = if2.v_err_addr;
  assign ecnt_a[0]  = if0.v_err_count;  assign ecnt_a[1]  = if1.v_err_count;  assign ecnt_a[2]  = if2.v_err_count;

  // ---------------- S-RAM read models (data valid LAT clocks after r_rden, then held) ----------------
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] pd [N][3];
  logic          pv [N][3];
  logic [DW-1:0] qh [N];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        qh[k] <= '0;
        for (int s = 0; s < 3; s++) begin
          pd[k][s] <= '0;
          pv[k][s] <= 1'b0;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (pv[k][LAT[k]-1]) qh[k] <= pd[k][LAT[k]-1];
        pd[k][0] <= mem[addr_a[k]];
        pv[k][0] <= rden_v[k];
        for (int s = 1; s < 3; s++) begin
          pd[k][s] <= pd[k][s-1];
          pv[k][s] <= pv[k][s-1];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      q_a[k] = pv[k][LAT[k]-1] ? pd[k][LAT[k]-1] : qh[k];
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  vm_state_t     tr_st [8];
  logic          tr_rden [8];
  logic [AW-1:0] tr_addr [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: apply the check rule to every location in address order.
  task automatic model_push(input int mode, input int rd_lat);
    bit seen [DEPTH];
    int cnt   = 0;
    int first = 0;
    bit bad;
    for (int i = 0; i < DEPTH; i++) begin
      if (mode == 0) bad = (int'(mem[i]) != i);
      else           bad = seen[mem[i]];
      if (mode == 1) seen[mem[i]] = 1'b1;
      if (bad) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
    exp_q.push_back(32'(cnt == 0));
    exp_q.push_back(32'(first));
    exp_q.push_back(32'((cnt > DEPTH) ? DEPTH : cnt));
    exp_q.push_back(32'(1 + DEPTH * (rd_lat + 3)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_reset_vals(input int k, input string tag);
    check({tag, ":state"},   32'(st_a[k]),    32'(IDLE));
    check({tag, ":r_rden"},  32'(rden_v[k]),  32'd0);
    check({tag, ":r_addr"},  32'(addr_a[k]),  32'd0);
    check({tag, ":v_done"},  32'(done_v[k]),  32'd0);
    check({tag, ":v_pass"},  32'(pass_v[k]),  32'd0);
    check({tag, ":err_addr"}, 32'(eaddr_a[k]), 32'd0);
    check({tag, ":err_cnt"}, 32'(ecnt_a[k]),  32'd0);
  endtask

  task automatic run_walk(input int k, input string tag);
    int   cyc = 0;
    int   pulses = 0;
    int   bad_addr = 0;
    int   dbl = 0;
    logic prev = 1'b0;
    logic [31:0] e_pass, e_addr, e_cnt, e_lat;
    @(negedge clk);
    start_v[k] = 1'b1;
    while (cyc < MAXCYC) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < 8) begin
        tr_st[cyc]   = st_a[k];
        tr_rden[cyc] = rden_v[k];
        tr_addr[cyc] = addr_a[k];
      end
      if (rden_v[k]) begin
        if (int'(addr_a[k]) != pulses) bad_addr++;
        if (prev) dbl++;
        pulses++;
      end
      prev = rden_v[k];
      if (done_v[k]) break;
    end
    e_pass = exp_q.pop_front();
    e_addr = exp_q.pop_front();
    e_cnt  = exp_q.pop_front();
    e_lat  = exp_q.pop_front();
    check({tag, ":latency"},   32'(cyc),        e_lat);
    check({tag, ":v_pass"},    32'(pass_v[k]),  e_pass);
    check({tag, ":err_addr"},  32'(eaddr_a[k]), e_addr);
    check({tag, ":err_cnt"},   32'(ecnt_a[k]),  e_cnt);
    check({tag, ":rd_pulses"}, 32'(pulses),     32'(DEPTH));
    check({tag, ":rd_order"},  32'(bad_addr),   32'd0);
    check({tag, ":rd_width"},  32'(dbl),        32'd0);
  endtask

  task automatic end_walk(input int k, input int hold, input string tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s:hold%0d", tag, i), 32'(st_a[k]), 32'(VERIFY_DONE));
    end
    start_v[k] = 1'b0;
    @(posedge clk);
    #1;
    check({tag, ":back_idle"}, 32'(st_a[k]),   32'(IDLE));
    check({tag, ":done_low"},  32'(done_v[k]), 32'd0);
  endtask

  task automatic fill_identity();
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
  endtask

  task automatic fill_perm_random();
    int j;
    logic [DW-1:0] t;
    fill_identity();
    for (int i = DEPTH - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = mem[i]; mem[i] = mem[j]; mem[j] = t;
    end
    repeat ($urandom_range(0, 3)) mem[$urandom_range(0, DEPTH-1)] = mem[$urandom_range(0, DEPTH-1)];
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    start_v = '0;
    fill_identity();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) check_reset_vals(i, $sformatf("rst%0d", i));
    @(negedge clk);
    reset = 1'b1;

    // Identity fill, clean walk, state trace, then start held high in VERIFY_DONE.
    model_push(0, 1);
    run_walk(0, "t1");
    check("t1:st1", 32'(tr_st[1]), 32'(SET_ADDR));
    check("t1:st2", 32'(tr_st[2]), 32'(WAIT_DATA));
    check("t1:st3", 32'(tr_st[3]), 32'(COMPARE));
    check("t1:st4", 32'(tr_st[4]), 32'(INC_COUNT));
    check("t1:st5", 32'(tr_st[5]), 32'(SET_ADDR));
    end_walk(0, 10, "t1");

    // Two planted errors.
    mem[8'h37] = 8'h00;
    mem[8'hC2] = 8'hFF;
    model_push(0, 1);
    run_walk(0, "t2");
    end_walk(0, 1, "t2");

    // Permutation check: reversed fill, then a duplicated value.
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(DEPTH - 1 - i);
    model_push(1, 1);
    run_walk(1, "t3a");
    end_walk(1, 1, "t3a");
    mem[10] = 8'h05;
    mem[20] = 8'h05;
    model_push(1, 1);
    run_walk(1, "t3b");
    end_walk(1, 1, "t3b");

    // Three-clock read latency.
    fill_identity();
    model_push(0, 3);
    run_walk(2, "t4");
    check("t4:rden1", 32'(tr_rden[1]), 32'd1);
    check("t4:rden2", 32'(tr_rden[2]), 32'd0);
    check("t4:addr2", 32'(tr_addr[2]), 32'd0);
    check("t4:addr4", 32'(tr_addr[4]), 32'd0);
    check("t4:st4",   32'(tr_st[4]),   32'(WAIT_DATA));
    check("t4:st5",   32'(tr_st[5]),   32'(COMPARE));
    check("t4:rden7", 32'(tr_rden[7]), 32'd1);
    check("t4:addr7", 32'(tr_addr[7]), 32'd1);
    end_walk(2, 1, "t4");

    // Reset in the middle of a walk that has already recorded an error.
    mem[5] = 8'h99;
    @(negedge clk);
    start_v[0] = 1'b1;
    repeat (300) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals(0, "t5");
    @(negedge clk);
    start_v[0] = 1'b0;
    reset = 1'b1;
    mem[5] = 8'h05;
    model_push(0, 1);
    run_walk(0, "t5r");
    end_walk(0, 1, "t5r");

    // Randomized fills across all three instances.
    for (int r = 0; r < 6; r++) begin
      k = r % 3;
      if (k == 1) begin
        fill_perm_random();
      end else begin
        fill_identity();
        repeat ($urandom_range(0, 5)) mem[$urandom_range(0, DEPTH-1)] = DW'($urandom);
      end
      model_push((k == 1) ? 1 : 0, LAT[k]);
      run_walk(k, $sformatf("rnd%0d", r));
      end_walk(k, $urandom_range(0, 3), $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
